// File: rtl/mux_pkg.sv
// Shared definitions for the mux_rr_arb slice: channel-count ceiling,
// index type and a one-hot to index helper.
package mux_pkg;

  localparam int unsigned MUX_MAX_NCH   = 16;
  localparam int unsigned MUX_SEL_MAX_W = $clog2(MUX_MAX_NCH);

  typedef logic [MUX_SEL_MAX_W-1:0] sel_t;

  function automatic sel_t onehot_to_idx(input logic [MUX_MAX_NCH-1:0] oh);
    sel_t idx;
    idx = '0;
    for (int unsigned i = 0; i < MUX_MAX_NCH; i++) begin
      if (oh[i]) idx = idx | sel_t'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/mux_rr_arb_rr_picker.sv
// Combinational round-robin picker: the first requester found cyclically
// after 'last', via a double-width request vector masked to the search window.
module rr_picker
  import mux_pkg::*;
#(
  parameter  int unsigned NCH   = 4,
  localparam int unsigned SEL_W = $clog2(NCH)
) (
  input  logic [NCH-1:0]   req,
  input  logic [SEL_W-1:0] last,
  input  logic             en,
  output logic [NCH-1:0]   grant,
  output logic [SEL_W-1:0] grant_idx,
  output logic             any
);

  logic [2*NCH-1:0]     dbl;
  logic [2*NCH-1:0]     mask;
  logic [2*NCH-1:0]     hit;
  logic [MUX_MAX_NCH-1:0] grant_ext;

  // Window (last, last+NCH] over the doubled vector covers every channel exactly
  // once and wraps without ever producing an index >= NCH.
  always_comb begin
    dbl  = {req, req};
    mask = '0;
    for (int unsigned k = 0; k < 2*NCH; k++) begin
      mask[k] = (k > 32'(last)) && (k <= 32'(last) + NCH);
    end
    hit   = dbl & mask;
    grant = '0;
    for (int unsigned k = 0; k < 2*NCH; k++) begin
      if (en && hit[k] && (grant == '0)) grant[k % NCH] = 1'b1;
    end
  end

  always_comb begin
    grant_ext            = '0;
    grant_ext[NCH-1:0]   = grant;
    grant_idx            = SEL_W'(onehot_to_idx(grant_ext));
  end

  assign any = |req;

endmodule

// File: rtl/mux_rr_arb.sv
// N-channel valid/ready mux with round-robin arbitration and one output register.
// Define MUX_RR_ARB_FIXED_PRIO_EN for fixed lowest-index-wins priority.
module mux_rr_arb
  import mux_pkg::*;
#(
  parameter  int unsigned WIDTH = 32,
  parameter  int unsigned NCH   = 4,
  localparam int unsigned SEL_W = $clog2(NCH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NCH*WIDTH-1:0] in_data,
  input  logic [NCH-1:0]       in_valid,
  output logic [NCH-1:0]       in_ready,
  output logic [WIDTH-1:0]     out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [SEL_W-1:0]     out_sel
);

  logic             load;
  logic             any;
  logic [NCH-1:0]   grant;
  logic [SEL_W-1:0] grant_idx;
  logic [SEL_W-1:0] last;
  logic [WIDTH-1:0] grant_data;

  assign load     = ~out_valid | out_ready;
  assign in_ready = grant;

`ifdef MUX_RR_ARB_FIXED_PRIO_EN
  // Pinning the pointer at NCH-1 makes the picker search from channel 0.
  assign last = SEL_W'(NCH - 1);
`else
  logic [SEL_W-1:0] last_grant;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)             last_grant <= SEL_W'(NCH - 1);
    else if (load && any)   last_grant <= grant_idx;
  end

  assign last = last_grant;
`endif

  rr_picker #(.NCH(NCH)) u_picker (
    .req       (in_valid),
    .last      (last),
    .en        (load),
    .grant     (grant),
    .grant_idx (grant_idx),
    .any       (any)
  );

  always_comb begin
    grant_data = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      if (grant[i]) grant_data = grant_data | in_data[i*WIDTH +: WIDTH];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= '0;
    end else if (load) begin
      if (any) begin
        out_valid <= 1'b1;
        out_data  <= grant_data;
        out_sel   <= grant_idx;
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mux_rr_arb.sv
// Scoreboard bench for mux_rr_arb (NCH=4 main instance, NCH=3 wrap instance).
module tb_mux_rr_arb;

  localparam int unsigned WIDTH = 32;
  localparam int unsigned NCH   = 4;
  localparam int unsigned SEL_W = 2;
  localparam int unsigned NCH3  = 3;

  logic                 clk;
  logic                 rst_n;
  logic [NCH*WIDTH-1:0] in_data;
  logic [NCH-1:0]       in_valid;
  logic [NCH-1:0]       in_ready;
  logic [WIDTH-1:0]     out_data;
  logic                 out_valid;
  logic                 out_ready;
  logic [SEL_W-1:0]     out_sel;

  logic [NCH3*WIDTH-1:0] in_data3;
  logic [NCH3-1:0]       in_valid3;
  logic [NCH3-1:0]       in_ready3;
  logic [WIDTH-1:0]      out_data3;
  logic                  out_valid3;
  logic                  out_ready3;
  logic [1:0]            out_sel3;

  mux_rr_arb #(.WIDTH(WIDTH), .NCH(NCH)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_sel(out_sel)
  );

  mux_rr_arb #(.WIDTH(WIDTH), .NCH(NCH3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data3), .in_valid(in_valid3),
    .in_ready(in_ready3), .out_data(out_data3), .out_valid(out_valid3),
    .out_ready(out_ready3), .out_sel(out_sel3)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct packed {
    logic [SEL_W-1:0] sel;
    logic [WIDTH-1:0] data;
  } beat_t;

  beat_t       sb[$];
  int          checks;
  int          errors;
  bit          m_valid;
  int unsigned m_last;

  int exp_rot[5];
  int exp_bp_next;
  int exp3[4];
  int exp13[4];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int model_pick(input logic [NCH-1:0] v);
`ifdef MUX_RR_ARB_FIXED_PRIO_EN
    for (int c = 0; c < NCH; c++) if (v[c]) return c;
`else
    for (int k = 1; k <= NCH; k++) begin
      int c;
      c = (int'(m_last) + k) % NCH;
      if (v[c]) return c;
    end
`endif
    return -1;
  endfunction

  task automatic set_data(input int c, input logic [WIDTH-1:0] d);
    in_data[c*WIDTH +: WIDTH] = d;
  endtask

  task automatic model_reset();
    m_valid = 1'b0;
    m_last  = NCH - 1;
    sb.delete();
  endtask

  // Called just after a falling edge with inputs already driven.
  task automatic tick();
    int             gi;
    logic [NCH-1:0] g;
    bit             load;
    beat_t          b;
    #4;
    load = !m_valid || out_ready;
    gi   = load ? model_pick(in_valid) : -1;
    g    = '0;
    if (gi >= 0) g[gi] = 1'b1;
    check("in_ready", in_ready, g);
    check("out_valid", out_valid, m_valid);
    if (m_valid && out_ready) begin
      if (sb.size() == 0) check("sb_nonempty", sb.size(), 1);
      else begin
        b = sb.pop_front();
        check("sb_data", out_data, b.data);
        check("sb_sel", out_sel, b.sel);
      end
    end
    if (load) begin
      if (gi >= 0) begin
        b.sel  = SEL_W'(gi);
        b.data = in_data[gi*WIDTH +: WIDTH];
        sb.push_back(b);
        m_valid = 1'b1;
        m_last  = gi;
      end else begin
        m_valid = 1'b0;
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    checks = 0; errors = 0;
    rst_n = 1'b0; in_data = '0; in_valid = '0; out_ready = 1'b0;
    in_data3 = '0; in_valid3 = '0; out_ready3 = 1'b0;
    model_reset();
`ifdef MUX_RR_ARB_FIXED_PRIO_EN
    exp_rot = '{0, 0, 0, 0, 0}; exp_bp_next = 0;
    exp3 = '{0, 0, 0, 0};       exp13 = '{1, 1, 1, 1};
`else
    exp_rot = '{0, 1, 2, 3, 0}; exp_bp_next = 1;
    exp3 = '{0, 2, 0, 2};       exp13 = '{1, 3, 1, 3};
`endif

    #1;
    check("rst_valid", out_valid, 0);
    check("rst_data", out_data, 0);
    check("rst_sel", out_sel, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Rotation with every channel requesting
    for (int c = 0; c < NCH; c++) set_data(c, WIDTH'(32'h10 + c));
    in_valid = '1; out_ready = 1'b1;
    for (int j = 0; j < 5; j++) begin
      tick();
      check("rot_sel", out_sel, exp_rot[j]);
      check("rot_data", out_data, 32'h10 + exp_rot[j]);
      check("rot_valid", out_valid, 1);
    end

    // Back-pressure holds the beat and blocks all inputs
    out_ready = 1'b0;
    for (int j = 0; j < 5; j++) begin
      tick();
      check("bp_sel", out_sel, exp_rot[4]);
      check("bp_data", out_data, 32'h10 + exp_rot[4]);
      check("bp_in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    tick();
    check("bp_next_sel", out_sel, exp_bp_next);
    check("bp_next_data", out_data, 32'h10 + exp_bp_next);

    // Idle drain after a single beat
    in_valid = '0;
    tick();
    check("drain_pre_valid", out_valid, 0);
    set_data(1, 32'hA5A5_0001);
    in_valid = 4'b0010;
    tick();
    check("single_valid", out_valid, 1);
    check("single_sel", out_sel, 1);
    check("single_data", out_data, 32'hA5A5_0001);
    in_valid = '0;
    tick();
    check("drain_valid", out_valid, 0);
    check("drain_data_hold", out_data, 32'hA5A5_0001);
    check("drain_sel_hold", out_sel, 1);
    tick();
    check("drain_valid2", out_valid, 0);

    // Asynchronous reset with a beat held
    set_data(0, 32'hDEAD_BEEF);
    in_valid = 4'b0001; out_ready = 1'b0;
    tick();
    check("pre_rst_data", out_data, 32'hDEAD_BEEF);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_valid", out_valid, 0);
    check("async_rst_data", out_data, 0);
    check("async_rst_sel", out_sel, 0);
    model_reset();
    in_valid = '0;
    @(negedge clk);
    rst_n = 1'b1;

    // Sparse requesters on the 3-channel instance, exercising the wrap
    for (int c = 0; c < NCH3; c++) in_data3[c*WIDTH +: WIDTH] = WIDTH'(32'h30 + c);
    in_valid3 = 3'b101; out_ready3 = 1'b1;
    for (int j = 0; j < 4; j++) begin
      tick();
      check("wrap_sel", out_sel3, exp3[j]);
      check("wrap_data", out_data3, 32'h30 + exp3[j]);
      check("wrap_sel_range", out_sel3 < 2'd3, 1);
    end
    in_valid3 = '0;

    // Channels 1 and 3 continuously valid
    for (int c = 0; c < NCH; c++) set_data(c, WIDTH'(32'h50 + c));
    in_valid = 4'b1010; out_ready = 1'b1;
    for (int j = 0; j < 4; j++) begin
      tick();
      check("pair_sel", out_sel, exp13[j]);
    end

    // Random traffic and back-pressure
    for (int n = 0; n < 300; n++) begin
      for (int c = 0; c < NCH; c++) set_data(c, WIDTH'($urandom));
      in_valid  = NCH'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      tick();
    end

    in_valid = '0; out_ready = 1'b1;
    tick();
    tick();
    check("final_idle", out_valid, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
